// File: rtl/arb_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arb_pixel_fifo
// Brief    : Tagged first-word-fall-through FIFO between the two-slave arbiter
//            and the processing engine, with overflow/drop diagnostics.
// Revision : 1.0 - initial release
// ============================================================================
module arb_pixel_fifo #(
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_valid,
    input  logic [DW-1:0]              wr_data,
    input  logic [1:0]                 wr_mode,
    input  logic                       wr_src,
    input  logic                       wr_proc_val,
    output logic                       fifo_full,
    output logic                       fifo_almost_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DW-1:0]              rd_data,
    output logic [1:0]                 rd_mode,
    output logic                       rd_src,
    output logic                       rd_proc_val,
    output logic                       ovf_err,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + 4;

    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
    localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);

    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_full;
    logic           r_almost_full;
    logic           r_empty;
    logic [EW-1:0]  r_head;
    logic           r_ovf_err;
    logic [7:0]     r_drop_cnt;

    logic           w_wr_req;
    logic           w_accept;
    logic           w_reject;
    logic           w_fire;
    logic [CW-1:0]  w_count_nxt;
    logic [CW-1:0]  w_remain;
    logic [AW-1:0]  w_rd_ptr_nxt;
    logic [EW-1:0]  w_wr_entry;
    logic [EW-1:0]  w_head_nxt;

    // Mode 00 is the arbiter's idle encoding and never enters the FIFO.
    assign w_wr_req   = wr_valid && (wr_mode != 2'b00) && !flush;
    assign w_accept   = w_wr_req && !r_full;
    assign w_reject   = w_wr_req && r_full;
    assign w_fire     = !r_empty && rd_ready && !flush;
    assign w_wr_entry = {wr_proc_val, wr_src, wr_mode, wr_data};

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_accept && !w_fire) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_fire && !w_accept) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // The head register is preloaded with whatever will sit at rd_ptr after
    // this edge; when the surviving occupancy is zero that is the incoming
    // word itself, because it lands exactly at the new read pointer.
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_fire);
    assign w_remain     = r_count - CW'(w_fire);
    assign w_head_nxt   = (w_remain == '0) ? w_wr_entry : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_empty       <= 1'b1;
            r_head        <= '0;
        end else begin
            r_count       <= w_count_nxt;
            r_full        <= (w_count_nxt == c_depth);
            r_almost_full <= (w_count_nxt >= c_af_level);
            r_empty       <= (w_count_nxt == '0);
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_accept) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                r_rd_ptr <= w_rd_ptr_nxt;
                // With nothing left the head keeps its last presented value.
                if (w_count_nxt != '0) begin
                    r_head <= w_head_nxt;
                end
            end
        end
    end

    // Diagnostics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_reject) begin
            r_ovf_err <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign fifo_full        = r_full;
    assign fifo_almost_full = r_almost_full;
    assign fifo_empty       = r_empty;
    assign fifo_count       = r_count;
    assign rd_valid         = !r_empty;
    assign rd_data          = r_head[DW-1:0];
    assign rd_mode          = r_head[DW+1:DW];
    assign rd_src           = r_head[DW+2];
    assign rd_proc_val      = r_head[DW+3];
    assign ovf_err          = r_ovf_err;
    assign drop_cnt         = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arb_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_pixel_fifo
// Brief    : Directed self-checking bench for arb_pixel_fifo (DW=32, DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_pixel_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [1:0]  wr_mode;
    logic        wr_src;
    logic        wr_proc_val;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_mode;
    logic        rd_src;
    logic        rd_proc_val;
    logic        ovf_err;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    arb_pixel_fifo #(.DW(32), .DEPTH(16), .AF_LEVEL(14)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_mode          (wr_mode),
        .wr_src           (wr_src),
        .wr_proc_val      (wr_proc_val),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_empty       (fifo_empty),
        .fifo_count       (fifo_count),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .rd_mode          (rd_mode),
        .rd_src           (rd_src),
        .rd_proc_val      (rd_proc_val),
        .ovf_err          (ovf_err),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic v, input logic [31:0] d, input logic [1:0] m,
                            input logic s, input logic pv);
        wr_valid    = v;
        wr_data     = d;
        wr_mode     = m;
        wr_src      = s;
        wr_proc_val = pv;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, 64'(fifo_empty), 64'd1);
        check({tag, "_full"},  64'(fifo_full), 64'd0);
        check({tag, "_af"},    64'(fifo_almost_full), 64'd0);
        check({tag, "_count"}, 64'(fifo_count), 64'd0);
        check({tag, "_rdv"},   64'(rd_valid), 64'd0);
        check({tag, "_head"},  64'({rd_proc_val, rd_src, rd_mode, rd_data}), 64'd0);
        check({tag, "_ovf"},   64'(ovf_err), 64'd0);
        check({tag, "_drop"},  64'(drop_cnt), 64'd0);
    endtask

    logic [1:0] t_mode [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    logic       t_src  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       t_pv   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        rd_ready = 1'b0;
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        check_reset_state("rst");
        rst = 1'b0;

        // Three words, no consumer; first word visible one cycle after accept.
        for (int i = 0; i < 3; i++) begin
            drive_wr(1'b1, 32'hA1 + i, 2'd1, 1'b0, 1'b0);
            tick();
            if (i == 0) begin
                check("lat_rdv",  64'(rd_valid), 64'd1);
                check("lat_data", 64'(rd_data), 64'hA1);
            end
        end
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        check("w3_count", 64'(fifo_count), 64'd3);
        check("w3_head",  64'(rd_data), 64'hA1);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd3_data%0d", i), 64'(rd_data), 64'hA1 + i);
            tick();
        end
        check("rd3_empty", 64'(fifo_empty), 64'd1);
        check("rd3_rdv",   64'(rd_valid), 64'd0);
        check("rd3_hold",  64'(rd_data), 64'hA3);
        rd_ready = 1'b0;

        // Fill to full, watching the almost-full threshold.
        for (int i = 0; i < 16; i++) begin
            drive_wr(1'b1, 32'h100 + i, 2'd1, 1'b0, 1'b0);
            tick();
            if (i == 12) check("af_at13", 64'(fifo_almost_full), 64'd0);
            if (i == 13) check("af_at14", 64'(fifo_almost_full), 64'd1);
            if (i == 14) check("full_at15", 64'(fifo_full), 64'd0);
        end
        check("full_at16", 64'(fifo_full), 64'd1);
        check("cnt_at16",  64'(fifo_count), 64'd16);
        // 17th write with a simultaneous read: still rejected.
        drive_wr(1'b1, 32'h1FF, 2'd1, 1'b0, 1'b0);
        rd_ready = 1'b1;
        tick();
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        check("ovf17_err",   64'(ovf_err), 64'd1);
        check("ovf17_drop",  64'(drop_cnt), 64'd1);
        check("ovf17_count", 64'(fifo_count), 64'd15);
        check("ovf17_full",  64'(fifo_full), 64'd0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_data%0d", i), 64'(rd_data), 64'h100 + i);
            tick();
        end
        check("drain_empty", 64'(fifo_empty), 64'd1);
        rd_ready = 1'b0;

        // Tagged entries, then an idle-mode write that must vanish.
        for (int i = 0; i < 6; i++) begin
            drive_wr(1'b1, 32'h300 + i, t_mode[i], t_src[i], t_pv[i]);
            tick();
        end
        drive_wr(1'b1, 32'hDEAD, 2'd0, 1'b1, 1'b1);
        tick();
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        check("idle_count", 64'(fifo_count), 64'd6);
        check("idle_drop",  64'(drop_cnt), 64'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tag_entry%0d", i),
                  64'({rd_proc_val, rd_src, rd_mode, rd_data}),
                  64'({t_pv[i], t_src[i], t_mode[i], 32'h300 + i}));
            tick();
        end
        check("tag_empty", 64'(fifo_empty), 64'd1);
        rd_ready = 1'b0;

        // Streaming at occupancy 2 across multiple pointer wraps.
        for (int i = 0; i < 2; i++) begin
            drive_wr(1'b1, 32'h200 + i, 2'd2, 1'b1, 1'b0);
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_wr(1'b1, 32'h202 + i, 2'd2, 1'b1, 1'b0);
            check($sformatf("strm_data%0d", i), 64'(rd_data), 64'h200 + i);
            tick();
            check($sformatf("strm_cnt%0d", i), 64'(fifo_count), 64'd2);
        end
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("strm_tail%0d", i), 64'(rd_data), 64'h228 + i);
            tick();
        end
        check("strm_empty", 64'(fifo_empty), 64'd1);
        rd_ready = 1'b0;

        // Drop counter saturation, then flush keeps diagnostics.
        for (int i = 0; i < 16; i++) begin
            drive_wr(1'b1, 32'h400 + i, 2'd3, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            drive_wr(1'b1, 32'h500 + i, 2'd3, 1'b0, 1'b1);
            tick();
            if (i == 100) check("sat_mid", 64'(drop_cnt), 64'd102);
        end
        check("sat_drop", 64'(drop_cnt), 64'd255);
        check("sat_full", 64'(fifo_full), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        check("flush_empty", 64'(fifo_empty), 64'd1);
        check("flush_count", 64'(fifo_count), 64'd0);
        check("flush_full",  64'(fifo_full), 64'd0);
        check("flush_drop",  64'(drop_cnt), 64'd255);
        check("flush_ovf",   64'(ovf_err), 64'd1);

        // A write during flush from a partly filled FIFO is dropped silently.
        drive_wr(1'b1, 32'h600, 2'd1, 1'b0, 1'b0);
        tick();
        drive_wr(1'b1, 32'h601, 2'd1, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        check("fl2_count", 64'(fifo_count), 64'd0);
        drive_wr(1'b1, 32'h602, 2'd1, 1'b0, 1'b0);
        tick();
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        check("fl2_new_head", 64'(rd_data), 64'h602);
        check("fl2_new_cnt",  64'(fifo_count), 64'd1);

        // Reset mid-stream wins over flush and a concurrent write.
        for (int i = 0; i < 4; i++) begin
            drive_wr(1'b1, 32'h700 + i, 2'd1, 1'b1, 1'b1);
            tick();
        end
        check("pre_rst_count", 64'(fifo_count), 64'd5);
        rst = 1'b1;
        flush = 1'b1;
        drive_wr(1'b1, 32'h7FF, 2'd1, 1'b1, 1'b1);
        tick();
        check_reset_state("mid_rst");
        tick();
        check_reset_state("hold_rst");
        rst = 1'b0;
        flush = 1'b0;
        drive_wr(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
